memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the 1024x8 synchronous read/write memory.
//  Requesters A (CPU side) and B (DMA/loader side) issue single-beat read or write transactions.
//  The block serialises them onto the memory's read/write strobes, address and data lines.
//  It captures read data and returns it with a one-cycle ack pulse.
// PARAMETERS
//  ADDR_W   10  address width; memory depth 2**ADDR_W
//  DATA_W    8  data width
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  rst          in   1       reset, synchronous, active-high; shared with the memory
//  a_req        in   1       A transaction request; held with a_we/a_addr/a_wdata until a_ack
//  a_we         in   1       1 = write, 0 = read
//  a_addr       in   ADDR_W  A address
//  a_wdata      in   DATA_W  A write data
//  a_ack        out  1       one-cycle pulse: A transaction complete
//  a_rdata      out  DATA_W  A read data; valid when a_ack=1 after a read, held until next A read ack
//  b_req, b_we, b_addr, b_wdata, b_ack, b_rdata   same as A, requester B
//  mem_rd_req   out  1       memory read strobe (drives MRead_request)
//  mem_wr_req   out  1       memory write strobe (drives MWrite_request)
//  mem_raddr    out  ADDR_W  memory read address
//  mem_waddr    out  ADDR_W  memory write address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read_data (registered inside memory, valid one edge after strobe)
//  busy         out  1       1 while a read is in flight (state != IDLE)
// BEHAVIOUR
//  - All outputs are registered. Reset values: every output 0, state IDLE, last_grant = B (so A wins first tie).
//  - Eligibility: X_req=1 and X_ack=0. A requester is ignored in the cycle its ack is high, so a req still held there is never reissued.
//  - Arbitration in IDLE only: one eligible requester wins. If both are eligible, the winner is the one not equal to last_grant.
//  - last_grant updates on every grant.
//  - FSM states: IDLE, RD_ISSUE, RD_CAP.
//  - IDLE, winner write (edge E0): mem_wr_req<=1, mem_waddr/mem_wdata<=winner's fields, winner ack<=1, stay IDLE.
//    The memory writes at E1. Write ack appears 1 cycle after req is sampled.
//    Back-to-back writes from alternating requesters sustain one per cycle.
//  - IDLE, winner read (E0): mem_rd_req<=1, mem_raddr<=addr, record owner, ->RD_ISSUE.
//  - RD_ISSUE (E1): memory samples strobe; mem_rd_req<=0; ->RD_CAP.
//  - RD_CAP (E2): owner rdata<=mem_rdata, owner ack<=1, ->IDLE.
//    Read ack appears 3 cycles after req is sampled. No grant is issued in RD_ISSUE or RD_CAP; requests wait.
//  - mem_rd_req and mem_wr_req are single-cycle pulses, never high together; at most one ack high per cycle.
//  - Write strobe deasserts the cycle after issue unless a new write is granted.
//  - mem_raddr, mem_waddr and mem_wdata hold their last values when idle.
//  - Addresses pass through unmodified; all 2**ADDR_W addresses are legal, with no wrap or range check.
//  - rst at any time, including mid-read: state->IDLE, strobes/acks/busy->0, rdata regs->0.
//    An in-flight read is dropped with no ack; the requester must re-request.
//    Memory contents are cleared by the memory on the same rst.
//  - Request fields changing while req=1 before ack: undefined; the bench must not do it.
// TESTING
//  1. A write 0x005<=0xA5 -> mem_wr_req pulse with waddr 0x005/wdata 0xA5, a_ack next cycle.
//     Then A read 0x005 -> a_ack 3 cycles after req with a_rdata=0xA5.
//  2. After reset, A write 0x010<=0x11 and B write 0x011<=0x22 raised together -> A granted first, B next cycle.
//     Readback gives 0x11 and 0x22.
//  3. A and B hold read requests continuously (0x100/0x200 preloaded 0x33/0x44) -> grants alternate A,B,A,B.
//     No requester is skipped; no mem_rd_req while busy=1.
//  4. Boundary addresses: write/read 0x3FF<=0xFF and 0x000<=0x01 -> correct data.
//     Neighbouring locations are untouched.
//  5. rst asserted while in RD_CAP -> no a_ack, all outputs 0 next cycle, state IDLE.
//     A subsequent read of any address returns 0x00.
//  6. Requester keeps req high through its ack cycle, then drops it -> exactly one memory access is issued.
//     Applies to both read and write.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Requester and memory-side signal bundle for memory_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface memory_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;
   logic [DATA_W-1:0] a_rdata;
   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;
   logic [DATA_W-1:0] b_rdata;
   logic              mem_rd_req;
   logic              mem_wr_req;
   logic [ADDR_W-1:0] mem_raddr;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  mem_rdata,
      output a_ack, a_rdata, b_ack, b_rdata,
      output mem_rd_req, mem_wr_req,
      output mem_raddr, mem_waddr, mem_wdata,
      output busy
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output mem_rdata,
      input  a_ack, a_rdata, b_ack, b_rdata,
      input  mem_rd_req, mem_wr_req,
      input  mem_raddr, mem_waddr, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin two-requester sequencer for a synchronous 1R/1W memory.
// Writes complete in one cycle; reads take issue + capture cycles.
module memory_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   memory_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RD_ISSUE,
      RD_CAP
   } state_e;

   state_e            state_q, state_d;
   logic              last_b_q, last_b_d;
   logic              owner_b_q, owner_b_d;
   logic              a_ack_q, a_ack_d;
   logic              b_ack_q, b_ack_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              busy_q, busy_d;

   logic              a_elig, b_elig;
   logic              grant_b;
   logic              g_we;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata;

   // A requester whose ack is high this cycle is ignored.
   assign a_elig  = bus.a_req & ~a_ack_q;
   assign b_elig  = bus.b_req & ~b_ack_q;
   assign grant_b = b_elig & (~a_elig | ~last_b_q);
   assign g_we    = grant_b ? bus.b_we    : bus.a_we;
   assign g_addr  = grant_b ? bus.b_addr  : bus.a_addr;
   assign g_wdata = grant_b ? bus.b_wdata : bus.a_wdata;

   always_comb begin
      state_d   = state_q;
      last_b_d  = last_b_q;
      owner_b_d = owner_b_q;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      raddr_d   = raddr_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (a_elig | b_elig) begin
               last_b_d = grant_b;
               if (g_we) begin
                  wr_d    = 1'b1;
                  waddr_d = g_addr;
                  wdata_d = g_wdata;
                  a_ack_d = ~grant_b;
                  b_ack_d = grant_b;
               end else begin
                  rd_d      = 1'b1;
                  raddr_d   = g_addr;
                  owner_b_d = grant_b;
                  state_d   = RD_ISSUE;
               end
            end
         end
         RD_ISSUE: state_d = RD_CAP;
         RD_CAP: begin
            if (owner_b_q) begin
               b_rdata_d = bus.mem_rdata;
               b_ack_d   = 1'b1;
            end else begin
               a_rdata_d = bus.mem_rdata;
               a_ack_d   = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_b_q  <= 1'b1;
         owner_b_q <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         raddr_q   <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_b_q  <= last_b_d;
         owner_b_q <= owner_b_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         raddr_q   <= raddr_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.a_ack      = a_ack_q;
   assign bus.b_ack      = b_ack_q;
   assign bus.a_rdata    = a_rdata_q;
   assign bus.b_rdata    = b_rdata_q;
   assign bus.mem_rd_req = rd_q;
   assign bus.mem_wr_req = wr_q;
   assign bus.mem_raddr  = raddr_q;
   assign bus.mem_waddr  = waddr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: behavioural 1024x8 memory, reference
// memory image and round-robin latency model, random plus directed traffic.
module tb_memory_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   memory_arbiter_if bus ();

   memory_arbiter dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [7:0] mem [1024];
   logic [7:0] mem_q;
   assign bus.mem_rdata = mem_q;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         mem_q <= 8'h00;
      end else begin
         if (bus.mem_wr_req) mem[bus.mem_waddr] <= bus.mem_wdata;
         if (bus.mem_rd_req) mem_q <= mem[bus.mem_raddr];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference state: expected memory image and who was granted last.
   logic [7:0] ref_mem [1024];
   bit         last_b;

   int         n_rd = 0;
   int         n_wr = 0;
   logic [9:0] lw_addr, lr_addr;
   logic [7:0] lw_data;
   bit         prev_busy, prev_rd;

   always @(negedge clk) begin
      if (rst) begin
         prev_busy = 1'b0;
         prev_rd   = 1'b0;
      end else begin
         chk("rdwr_excl", 64'(bus.mem_rd_req & bus.mem_wr_req), 0);
         chk("ack_excl", 64'(bus.a_ack & bus.b_ack), 0);
         chk("rd_pulse", 64'(bus.mem_rd_req & (prev_busy | prev_rd)), 0);
         if (bus.mem_rd_req) begin
            n_rd++;
            lr_addr = bus.mem_raddr;
         end
         if (bus.mem_wr_req) begin
            n_wr++;
            lw_addr = bus.mem_waddr;
            lw_data = bus.mem_wdata;
         end
         prev_busy = bus.busy;
         prev_rd   = bus.mem_rd_req;
      end
   end

   function automatic logic [63:0] outs();
      return {15'd0, bus.a_ack, bus.b_ack, bus.a_rdata, bus.b_rdata,
              bus.mem_rd_req, bus.mem_wr_req, bus.mem_raddr,
              bus.mem_waddr, bus.mem_wdata, bus.busy};
   endfunction

   function automatic int cost(bit we);
      return we ? 1 : 3;
   endfunction

   task automatic clear_ref();
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      last_b = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_ref();
   endtask

   task automatic set_req(bit isb, bit v);
      if (isb) bus.b_req = v;
      else bus.a_req = v;
   endtask

   task automatic txn(input bit isb, input bit we,
                      input logic [9:0] addr, input logic [7:0] wd,
                      input bit hold,
                      output logic [7:0] rd, output int lat);
      bit got;
      got = 1'b0;
      lat = 0;
      rd = 8'h00;
      @(posedge clk);
      #1;
      if (isb) begin
         bus.b_we = we;
         bus.b_addr = addr;
         bus.b_wdata = wd;
      end else begin
         bus.a_we = we;
         bus.a_addr = addr;
         bus.a_wdata = wd;
      end
      set_req(isb, 1'b1);
      while (!got && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         got = isb ? bus.b_ack : bus.a_ack;
      end
      if (!got) begin
         chk("ack_timeout", 0, 1);
         lat = 99;
      end else begin
         rd = isb ? bus.b_rdata : bus.a_rdata;
         if (we) ref_mem[addr] = wd;
         if (hold) begin
            @(posedge clk);
            #1;
         end
      end
      set_req(isb, 1'b0);
   endtask

   task automatic solo(string tag, bit isb, bit we, logic [9:0] addr,
                       logic [7:0] wd, bit hold);
      int lat, s_rd, s_wr;
      logic [7:0] rd, exp;
      exp = ref_mem[addr];
      s_rd = n_rd;
      s_wr = n_wr;
      txn(isb, we, addr, wd, hold, rd, lat);
      last_b = isb;
      chk({tag, "_lat"}, 64'(lat), 64'(cost(we)));
      if (!we) chk({tag, "_rdata"}, 64'(rd), 64'(exp));
      @(posedge clk);
      #1;
      chk({tag, "_acc"}, {32'(n_wr - s_wr), 32'(n_rd - s_rd)},
          {32'(we), 32'(!we)});
      if (we) chk({tag, "_wbus"}, {lw_addr, lw_data}, {addr, wd});
      else chk({tag, "_raddr"}, 64'(lr_addr), 64'(addr));
   endtask

   // Both requesters raised in the same cycle: winner is the one not
   // granted last; loser waits for the winner's full transaction.
   task automatic pair(string tag,
                       bit wea, logic [9:0] ada, logic [7:0] wda,
                       bit web, logic [9:0] adb, logic [7:0] wdb,
                       bit hold);
      int la, lb, s_rd, s_wr, ea, eb;
      logic [7:0] ra, rb, xa, xb;
      bit win_b;
      xa = ref_mem[ada];
      xb = ref_mem[adb];
      s_rd = n_rd;
      s_wr = n_wr;
      win_b = !last_b;
      ea = win_b ? cost(web) + cost(wea) : cost(wea);
      eb = win_b ? cost(web) : cost(wea) + cost(web);
      fork
         txn(1'b0, wea, ada, wda, hold, ra, la);
         txn(1'b1, web, adb, wdb, hold, rb, lb);
      join
      last_b = !win_b;
      chk({tag, "_lat_a"}, 64'(la), 64'(ea));
      chk({tag, "_lat_b"}, 64'(lb), 64'(eb));
      if (!wea) chk({tag, "_rdata_a"}, 64'(ra), 64'(xa));
      if (!web) chk({tag, "_rdata_b"}, 64'(rb), 64'(xb));
      @(posedge clk);
      #1;
      chk({tag, "_acc"}, {32'(n_wr - s_wr), 32'(n_rd - s_rd)},
          {32'(wea + web), 32'(2 - wea - web)});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      bit wa, wb, hd;
      logic [9:0] aa, ab;
      int acks;
      bit exp_b;

      bus.a_req = 1'b0;
      bus.a_we = 1'b0;
      bus.a_addr = '0;
      bus.a_wdata = '0;
      bus.b_req = 1'b0;
      bus.b_we = 1'b0;
      bus.b_addr = '0;
      bus.b_wdata = '0;

      do_reset();
      chk("reset_outs", outs(), 0);

      solo("t1_wr", 1'b0, 1'b1, 10'h005, 8'hA5, 1'b0);
      solo("t1_rd", 1'b0, 1'b0, 10'h005, 8'h00, 1'b0);

      do_reset();
      pair("t2_wr", 1'b1, 10'h010, 8'h11, 1'b1, 10'h011, 8'h22, 1'b0);
      solo("t2_rda", 1'b0, 1'b0, 10'h010, 8'h00, 1'b0);
      solo("t2_rdb", 1'b1, 1'b0, 10'h011, 8'h00, 1'b0);

      solo("t4_w0", 1'b0, 1'b1, 10'h3FE, 8'h5A, 1'b0);
      solo("t4_w1", 1'b1, 1'b1, 10'h001, 8'hC3, 1'b0);
      solo("t4_w2", 1'b0, 1'b1, 10'h3FF, 8'hFF, 1'b0);
      solo("t4_w3", 1'b1, 1'b1, 10'h000, 8'h01, 1'b0);
      solo("t4_r0", 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0);
      solo("t4_r1", 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
      solo("t4_r2", 1'b1, 1'b0, 10'h3FE, 8'h00, 1'b0);
      solo("t4_r3", 1'b0, 1'b0, 10'h001, 8'h00, 1'b0);

      solo("t6_wr", 1'b0, 1'b1, 10'h055, 8'h9C, 1'b1);
      solo("t6_rd", 1'b1, 1'b0, 10'h055, 8'h00, 1'b1);

      for (int k = 0; k < 150; k++) begin
         r = $urandom;
         wa = r[0];
         wb = r[1];
         hd = r[2];
         aa = {r[12:4], 1'b0};
         ab = {r[21:13], 1'b1};
         if (r[25:23] == 3'd0) aa = 10'h000;
         if (r[28:26] == 3'd0) ab = 10'h3FF;
         case (r[31:30])
            2'd0: solo("rnd_a", 1'b0, wa, aa, 8'($urandom), hd);
            2'd1: solo("rnd_b", 1'b1, wb, ab, 8'($urandom), hd);
            default:
               pair("rnd_p", wa, aa, 8'($urandom),
                    wb, ab, 8'($urandom), hd);
         endcase
      end

      solo("t3_pa", 1'b0, 1'b1, 10'h100, 8'h33, 1'b0);
      solo("t3_pb", 1'b1, 1'b1, 10'h200, 8'h44, 1'b0);
      exp_b = !last_b;
      acks = 0;
      @(posedge clk);
      #1;
      bus.a_we = 1'b0;
      bus.a_addr = 10'h100;
      bus.b_we = 1'b0;
      bus.b_addr = 10'h200;
      bus.a_req = 1'b1;
      bus.b_req = 1'b1;
      for (int c = 0; c < 80 && acks < 8; c++) begin
         @(negedge clk);
         if (bus.a_ack | bus.b_ack) begin
            chk("rr_owner", 64'(bus.b_ack), 64'(exp_b));
            chk("rr_rdata",
                64'(bus.b_ack ? bus.b_rdata : bus.a_rdata),
                64'(bus.b_ack ? 8'h44 : 8'h33));
            exp_b = !exp_b;
            acks++;
         end
      end
      chk("rr_count", 64'(acks), 8);
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      repeat (4) @(posedge clk);

      do_reset();
      solo("t5_wr", 1'b0, 1'b1, 10'h020, 8'h77, 1'b0);
      @(posedge clk);
      #1;
      bus.a_we = 1'b0;
      bus.a_addr = 10'h020;
      bus.a_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_pre_ack", 64'(bus.a_ack), 0);
      @(posedge clk);
      #1;
      bus.a_req = 1'b0;
      @(negedge clk);
      chk("t5_outs", outs(), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_ref();
      solo("t5_rd0", 1'b0, 1'b0, 10'h020, 8'h00, 1'b0);
      solo("t5_rd1", 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
